ibex_fetch_align_fifo: RTL

- Parametrised instruction fetch FIFO between the memory-side prefetch logic and the IF-ID pipeline register.
- Stores up to Depth 32-bit fetched words with per-word bus-error flags.
- Realigns the stream so each output is one complete instruction (16-bit compressed or 32-bit, at any halfword offset), with its PC and the PC of the following instruction.
- Supports instructions that span a word boundary; the current fetch path assumes word-aligned fetch addresses.

---
 rtl/ibex_fetch_align_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ibex_fetch_align_fifo.sv
// Instruction fetch FIFO with halfword realignment.
// Buffers up to Depth fetched 32-bit words (with bus-error flags). Each output
// is one complete instruction (16-bit compressed or 32-bit, at any halfword
// offset), together with its PC and the PC of the next sequential instruction.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i, in_addr_i   flush all entries and load a new PC
//   busy_o               per-entry occupancy (entry 0 is the head)
//   in_valid_i/rdata/err fetched word from memory
//   out_valid_o/ready_i  instruction handshake
//   out_rdata_o          instruction (bits 31:16 don't-care when compressed)
//   out_addr_o           PC of out_rdata_o
//   out_addr_next_o      PC of the following instruction
//   out_err_o            fetch error on this instruction
//   out_err_plus2_o      error only in the second word of an unaligned 32-bit instr
module ibex_fetch_align_fifo #(
  parameter int unsigned Depth = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [31:0]      in_addr_i,
  output logic [Depth-1:0] busy_o,
  input  logic             in_valid_i,
  input  logic [31:0]      in_rdata_i,
  input  logic             in_err_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_rdata_o,
  output logic [31:0]      out_addr_o,
  output logic [31:0]      out_addr_next_o,
  output logic             out_err_o,
  output logic             out_err_plus2_o
);

  localparam int unsigned DataW = 32;

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] err_q, err_d;
  logic [DataW-1:0] rdata_q [Depth];
  logic [DataW-1:0] rdata_d [Depth];
  logic [DataW-1:0] addr_q, addr_d;

  logic             off;
  logic             w0_valid, w1_valid;
  logic [DataW-1:0] w0, w1;
  logic             w0_err, w1_err;
  logic             compressed;
  logic             unaligned32;
  logic             accept;
  logic             pop;
  logic             push_en;
  logic             placed;

  // Head/second word selection: stored entries first, incoming word fills the
  // first missing position so an instruction can complete in the arrival cycle.
  always_comb begin
    off      = addr_q[1];
    w0_valid = valid_q[0] | in_valid_i;
    w0       = valid_q[0] ? rdata_q[0] : in_rdata_i;
    w0_err   = valid_q[0] ? err_q[0] : (in_valid_i & in_err_i);
    w1_valid = valid_q[1] | (valid_q[0] & in_valid_i);
    w1       = valid_q[1] ? rdata_q[1] : in_rdata_i;
    w1_err   = valid_q[1] ? err_q[1] : (valid_q[0] & in_valid_i & in_err_i);
  end

  // Instruction decode, output formation and consumption.
  always_comb begin
    compressed  = off ? (w0[17:16] != 2'b11) : (w0[1:0] != 2'b11);
    unaligned32 = off & ~compressed;

    // A head-word error at offset 2 is reported without waiting for the next word.
    out_valid_o     = w0_valid & (~off | compressed | w0_err | w1_valid);
    out_rdata_o     = off ? {w1[15:0], w0[31:16]} : w0;
    out_err_o       = w0_err | (unaligned32 & w1_err);
    out_err_plus2_o = unaligned32 & w1_err & ~w0_err;
    out_addr_o      = addr_q;
    out_addr_next_o = addr_q + (compressed ? DataW'(2) : DataW'(4));

    accept = out_valid_o & out_ready_i;
    // Head word is used up unless only its low half was consumed.
    pop    = accept & (off | ~compressed);
  end

  // Storage next state: shift on pop, then place the incoming word in the
  // lowest free slot. A popped word taken straight from the input is never stored.
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    placed  = 1'b0;
    push_en = in_valid_i & ~(pop & ~valid_q[0]);

    if (pop) begin
      for (int unsigned i = 0; i < Depth - 1; i++) begin
        valid_d[i] = valid_q[i+1];
        err_d[i]   = err_q[i+1];
        rdata_d[i] = rdata_q[i+1];
      end
      valid_d[Depth-1] = 1'b0;
      err_d[Depth-1]   = 1'b0;
    end

    for (int unsigned i = 0; i < Depth; i++) begin
      if (push_en && !placed && !valid_d[i]) begin
        valid_d[i] = 1'b1;
        err_d[i]   = in_err_i;
        rdata_d[i] = in_rdata_i;
        placed     = 1'b1;
      end
    end

    if (clear_i) begin
      valid_d = '0;
    end
  end

  // PC tracking; a flush overrides any accept in the same cycle.
  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = {in_addr_i[31:1], 1'b0};
    end else if (accept) begin
      addr_d = out_addr_next_o;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= '0;
      addr_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o = valid_q;

  // Protocol and sanity checks.
  outputs_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({out_valid_o, out_addr_o, out_err_o}));

  no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in_valid_i && !clear_i && (&valid_q) && !pop));

  addr_halfword_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_addr_o[0] == 1'b0);

endmodule
